id_decode_stage: RTL

Instruction-decode stage sitting directly downstream of the IF/ID register. It decodes the latched instruction, reads the 32x32 register file (written back from WB) and detects load-use hazards. It drives the stall request back to IF and IF/ID, and holds the ID/EX pipeline register that feeds EX. MIPS subset: R-type, lw, sw, beq, addi.

---
 rtl/id_decode_stage_pkg.sv | 49 ++++
 rtl/id_decode_stage_if.sv | 49 ++++
 rtl/id_decode_stage_register_file.sv | 44 ++++
 rtl/id_decode_stage.sv | 112 +++++++++++
 4 files changed

// File: rtl/id_decode_stage_pkg.sv
// Shared types and constants for the ID stage:
// opcodes, ALUOp encodings and the ID/EX bundle.
package id_decode_stage_pkg;

  localparam int REG_COUNT = 32;
  localparam int DATA_W    = 32;
  localparam int REG_AW    = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  typedef struct packed {
    logic [DATA_W-1:0] pc_plus_four;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    ctrl_t             ctrl;
  } id_ex_t;

  function automatic logic [DATA_W-1:0] sign_ext(
    input logic [15:0] v
  );
    return {{(DATA_W-16){v[15]}}, v};
  endfunction

endpackage

// File: rtl/id_decode_stage_if.sv
// IF/ID, WB and ID/EX signals of the decode stage.
// master drives the stage inputs, slave is the stage.
interface id_decode_stage_if;
  import id_decode_stage_pkg::*;

  logic [DATA_W-1:0] PC_plus_four_in;
  logic [DATA_W-1:0] instruction_in;
  logic              flush;
  logic              wb_RegWrite;
  logic [REG_AW-1:0] wb_write_reg;
  logic [DATA_W-1:0] wb_write_data;
  logic              stall;
  logic [DATA_W-1:0] PC_plus_four_out;
  logic [DATA_W-1:0] read_data_1;
  logic [DATA_W-1:0] read_data_2;
  logic [DATA_W-1:0] sign_ext_imm;
  logic [REG_AW-1:0] rs_out;
  logic [REG_AW-1:0] rt_out;
  logic [REG_AW-1:0] rd_out;
  logic              RegDst;
  logic              ALUSrc;
  logic              MemRead;
  logic              MemWrite;
  logic              Branch;
  logic              MemtoReg;
  logic              RegWrite;
  logic [1:0]        ALUOp;

  modport master (
    output PC_plus_four_in, instruction_in, flush,
    output wb_RegWrite, wb_write_reg, wb_write_data,
    input  stall, PC_plus_four_out,
    input  read_data_1, read_data_2, sign_ext_imm,
    input  rs_out, rt_out, rd_out,
    input  RegDst, ALUSrc, MemRead, MemWrite,
    input  Branch, MemtoReg, RegWrite, ALUOp
  );

  modport slave (
    input  PC_plus_four_in, instruction_in, flush,
    input  wb_RegWrite, wb_write_reg, wb_write_data,
    output stall, PC_plus_four_out,
    output read_data_1, read_data_2, sign_ext_imm,
    output rs_out, rt_out, rd_out,
    output RegDst, ALUSrc, MemRead, MemWrite,
    output Branch, MemtoReg, RegWrite, ALUOp
  );

endinterface

// File: rtl/id_decode_stage_register_file.sv
// 2-read 1-write register file, r0 hard zero,
// same-cycle write-through to the read ports.
module register_file #(
  parameter int REG_COUNT = 32,
  parameter int DATA_W    = 32,
  parameter int AW        = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs_q [REG_COUNT];
  logic [DATA_W-1:0] regs_d [REG_COUNT];
  logic              wr_en;

  assign wr_en = we && (waddr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

  always_comb begin
    rdata1 = regs_q[raddr1];
    rdata2 = regs_q[raddr2];
    if (wr_en && waddr == raddr1) rdata1 = wdata;
    if (wr_en && waddr == raddr2) rdata2 = wdata;
    if (raddr1 == '0) rdata1 = '0;
    if (raddr2 == '0) rdata2 = '0;
  end

endmodule

// File: rtl/id_decode_stage.sv
// Decode stage: control decode, register read,
// load-use hazard detection and the ID/EX register.
module id_decode_stage
  import id_decode_stage_pkg::*;
#(
  parameter int REG_COUNT = 32,
  parameter int DATA_W    = 32
) (
  input logic              clock,
  input logic              reset_n,
  id_decode_stage_if.slave io
);

  logic [5:0]        opcode;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [DATA_W-1:0] rd1, rd2;
  ctrl_t             ctrl_dec;
  id_ex_t            id_ex_d, id_ex_q;
  logic              stall;

  assign opcode = io.instruction_in[31:26];
  assign rs     = io.instruction_in[25:21];
  assign rt     = io.instruction_in[20:16];
  assign rd     = io.instruction_in[15:11];

  register_file #(
    .REG_COUNT (REG_COUNT),
    .DATA_W    (DATA_W)
  ) u_rf (
    .clk    (clock),
    .rst_n  (reset_n),
    .we     (io.wb_RegWrite),
    .waddr  (io.wb_write_reg),
    .wdata  (io.wb_write_data),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

  always_comb begin
    ctrl_dec = '0;
    unique case (1'b1)
      (opcode == OP_RTYPE): begin
        ctrl_dec.reg_dst   = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_op    = ALUOP_FUNCT;
      end
      (opcode == OP_LW): begin
        ctrl_dec.alu_src    = 1'b1;
        ctrl_dec.mem_to_reg = 1'b1;
        ctrl_dec.reg_write  = 1'b1;
        ctrl_dec.mem_read   = 1'b1;
        ctrl_dec.alu_op     = ALUOP_ADD;
      end
      (opcode == OP_SW): begin
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.mem_write = 1'b1;
        ctrl_dec.alu_op    = ALUOP_ADD;
      end
      (opcode == OP_BEQ): begin
        ctrl_dec.branch = 1'b1;
        ctrl_dec.alu_op = ALUOP_SUB;
      end
      (opcode == OP_ADDI): begin
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_op    = ALUOP_ADD;
      end
      default: ;
    endcase
  end

  // rt of 0 also stalls: cheaper compare, one harmless extra bubble
  assign stall = id_ex_q.ctrl.mem_read &&
                 (id_ex_q.rt == rs || id_ex_q.rt == rt);

  always_comb begin
    id_ex_d              = '0;
    id_ex_d.pc_plus_four = io.PC_plus_four_in;
    id_ex_d.rd1          = rd1;
    id_ex_d.rd2          = rd2;
    id_ex_d.imm          = sign_ext(io.instruction_in[15:0]);
    id_ex_d.rs           = rs;
    id_ex_d.rt           = rt;
    id_ex_d.rd           = rd;
    id_ex_d.ctrl         = (io.flush || stall) ? '0 : ctrl_dec;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) id_ex_q <= '0;
    else          id_ex_q <= id_ex_d;
  end

  assign io.stall            = stall;
  assign io.PC_plus_four_out = id_ex_q.pc_plus_four;
  assign io.read_data_1      = id_ex_q.rd1;
  assign io.read_data_2      = id_ex_q.rd2;
  assign io.sign_ext_imm     = id_ex_q.imm;
  assign io.rs_out           = id_ex_q.rs;
  assign io.rt_out           = id_ex_q.rt;
  assign io.rd_out           = id_ex_q.rd;
  assign io.RegDst           = id_ex_q.ctrl.reg_dst;
  assign io.ALUSrc           = id_ex_q.ctrl.alu_src;
  assign io.MemtoReg         = id_ex_q.ctrl.mem_to_reg;
  assign io.RegWrite         = id_ex_q.ctrl.reg_write;
  assign io.MemRead          = id_ex_q.ctrl.mem_read;
  assign io.MemWrite         = id_ex_q.ctrl.mem_write;
  assign io.Branch           = id_ex_q.ctrl.branch;
  assign io.ALUOp            = id_ex_q.ctrl.alu_op;

endmodule
